// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and divisor helper
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Clock cycles per serial bit, rounded to the nearest integer.
    function automatic int calc_div(input real clk_freq, input real baud);
        return integer'(clk_freq / baud);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - two-flop synchronizer with configurable reset value
`timescale 1ns/1ps
module sync_bit #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; reset to RESET_VAL so release looks like an idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready byte output
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter real CLK_FREQUENCY = 50.0e6,
    parameter real BAUD_RATE     = 115200.0
) (
    input  logic       clk_50mhz,
    input  logic       arst_n,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int DIV   = calc_div(CLK_FREQUENCY, BAUD_RATE);
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);

    generate
        if (DIV < 16) begin : g_div_check
            $fatal(1, "uart_rx: clock/baud ratio below 16");
        end
    endgenerate

    logic              rxd_sync;
    logic              rxd_prev;
    logic              rxd_fall;

    uart_state_e       state_q, state_d;
    logic [CNT_W-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              byte_done;
    logic              frame_err_d;

    sync_bit #(
        .RESET_VAL (1'b1)
    ) u_sync_rxd (
        .clk   (clk_50mhz),
        .rst_n (arst_n),
        .d     (uart_rxd),
        .q     (rxd_sync)
    );

    // Delayed copy of the synchronized line for start-edge detection.
    always_ff @(posedge clk_50mhz or negedge arst_n) begin
        if (!arst_n) begin
            rxd_prev <= 1'b1;
        end else begin
            rxd_prev <= rxd_sync;
        end
    end

    // Only a genuine 1->0 transition starts a frame; a line held low never retriggers.
    assign rxd_fall = rxd_prev & ~rxd_sync;

    // Receiver state, counters and shift register.
    always_ff @(posedge clk_50mhz or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state: count down to mid-bit, sample, then act on the sampled value.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        byte_done   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (rxd_fall) begin
                    state_d = ST_START;
                    baud_d  = CNT_W'(HALF - 1);
                end
            end
            ST_START: begin
                if (baud_q != '0) begin
                    baud_d = baud_q - CNT_W'(1);
                end else if (!rxd_sync) begin
                    state_d = ST_DATA;
                    baud_d  = CNT_W'(DIV - 1);
                    bit_d   = '0;
                end else begin
                    // Line back high at mid start bit: treat as a glitch.
                    state_d = ST_IDLE;
                    baud_d  = '0;
                end
            end
            ST_DATA: begin
                if (baud_q != '0) begin
                    baud_d = baud_q - CNT_W'(1);
                end else begin
                    shift_d = {rxd_sync, shift_q[7:1]};
                    baud_d  = CNT_W'(DIV - 1);
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (baud_q != '0) begin
                    baud_d = baud_q - CNT_W'(1);
                end else begin
                    if (rxd_sync) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Output holding register: a completed byte is dropped if the previous one is still pending.
    always_ff @(posedge clk_50mhz or negedge arst_n) begin
        if (!arst_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= frame_err_d;
            rx_overrun   <= 1'b0;
            if (byte_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_q;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int DIV     = 434;
    localparam int HALF    = 217;
    localparam int LAT     = 3 + HALF + 9 * DIV;
    localparam int BIT_FST = 425;
    localparam int BIT_SLW = 443;

    logic       clk_50mhz;
    logic       arst_n;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;

    int n_checks;
    int n_fail;
    int cyc;
    int start_cyc;
    int first_valid_cyc;
    int valid_cycles;
    int ferr_cnt;
    int ovr_cnt;
    int busy_cycles;
    bit valid_prev;

    logic [7:0] exp_q[$];

    uart_rx dut (
        .clk_50mhz    (clk_50mhz),
        .arst_n       (arst_n),
        .uart_rxd     (uart_rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_busy      (rx_busy),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    initial clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    always @(posedge clk_50mhz) cyc++;

    // Scoreboard and event monitor, sampled mid-cycle.
    always @(negedge clk_50mhz) begin
        if (rx_valid && rx_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: unexpected byte 0x%02h, none expected", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard: got 0x%02h expected 0x%02h", rx_data, e);
                end
            end
        end
        if (rx_valid && !valid_prev) first_valid_cyc = cyc;
        valid_prev = rx_valid;
        if (rx_valid)     valid_cycles++;
        if (rx_frame_err) ferr_cnt++;
        if (rx_overrun)   ovr_cnt++;
        if (rx_busy)      busy_cycles++;
    end

    task automatic line_hold(input logic v, input int n);
        uart_rxd = v;
        repeat (n) @(posedge clk_50mhz);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input int bit_cyc, input logic stop_val);
        @(posedge clk_50mhz);
        #2;
        start_cyc = cyc;
        line_hold(1'b0, bit_cyc);
        for (int i = 0; i < 8; i++) line_hold(d[i], bit_cyc);
        line_hold(stop_val, bit_cyc);
    endtask

    task automatic test_reset();
        arst_n   = 1'b0;
        uart_rxd = 1'b1;
        rx_ready = 1'b0;
        repeat (4) @(posedge clk_50mhz);
        #2;
        n_checks++; if (rx_data !== 8'h00)   begin n_fail++; $display("FAIL reset_data: got 0x%02h expected 0x00", rx_data); end
        n_checks++; if (rx_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        n_checks++; if (rx_busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        n_checks++; if (rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", rx_frame_err); end
        n_checks++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", rx_overrun); end
        arst_n = 1'b1;
        line_hold(1'b1, 20);
        n_checks++; if (rx_busy !== 1'b0)    begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", rx_busy); end
    endtask

    task automatic test_single_byte();
        int v0, f0, o0, lat;
        rx_ready = 1'b1;
        v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
        first_valid_cyc = -1;
        exp_q.push_back(8'h55);
        send_frame(8'h55, DIV, 1'b1);
        line_hold(1'b1, 2 * DIV);
        lat = first_valid_cyc - start_cyc;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_missing: %0d bytes outstanding, expected 0", exp_q.size()); end
        n_checks++; if (valid_cycles - v0 != 1) begin n_fail++; $display("FAIL single_valid_cycles: got %0d expected 1", valid_cycles - v0); end
        n_checks++; if (lat < LAT - 2 || lat > LAT + 2) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d +/-2", lat, LAT); end
        n_checks++; if (ferr_cnt != f0 || ovr_cnt != o0) begin n_fail++; $display("FAIL single_errors: ferr %0d ovr %0d expected 0 0", ferr_cnt - f0, ovr_cnt - o0); end
    endtask

    task automatic test_back_to_back_overrun();
        int o0, f0;
        rx_ready = 1'b0;
        o0 = ovr_cnt; f0 = ferr_cnt;
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, DIV, 1'b1);
        line_hold(1'b1, DIV);
        send_frame(8'h5C, DIV, 1'b1);
        line_hold(1'b1, 2 * DIV);
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held: got %b expected 1", rx_valid); end
        n_checks++; if (rx_data !== 8'hA3) begin n_fail++; $display("FAIL ovr_data_kept: got 0x%02h expected 0xa3", rx_data); end
        n_checks++; if (ovr_cnt - o0 != 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_cnt - o0); end
        n_checks++; if (ferr_cnt != f0) begin n_fail++; $display("FAIL ovr_ferr: got %0d expected 0", ferr_cnt - f0); end
        @(posedge clk_50mhz);
        #2;
        rx_ready = 1'b1;
        @(posedge clk_50mhz);
        #2;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_clear: got %b expected 0", rx_valid); end
        n_checks++; if (rx_data !== 8'hA3) begin n_fail++; $display("FAIL ovr_data_hold: got 0x%02h expected 0xa3", rx_data); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovr_missing: %0d bytes outstanding, expected 0", exp_q.size()); end
    endtask

    task automatic test_frame_error();
        int v0, f0, b0;
        rx_ready = 1'b1;
        v0 = valid_cycles; f0 = ferr_cnt;
        send_frame(8'hFF, DIV, 1'b0);
        n_checks++; if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d expected 1", ferr_cnt - f0); end
        b0 = busy_cycles;
        line_hold(1'b0, 20 * DIV);
        n_checks++; if (busy_cycles != b0) begin n_fail++; $display("FAIL ferr_break_busy: got %0d busy cycles expected 0", busy_cycles - b0); end
        line_hold(1'b1, 2 * DIV);
        n_checks++; if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL ferr_total: got %0d expected 1", ferr_cnt - f0); end
        n_checks++; if (valid_cycles != v0) begin n_fail++; $display("FAIL ferr_valid: got %0d valid cycles expected 0", valid_cycles - v0); end
    endtask

    task automatic test_glitch();
        int v0, f0, o0, b0;
        v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt; b0 = busy_cycles;
        line_hold(1'b0, 50);
        line_hold(1'b1, DIV);
        n_checks++; if (busy_cycles - b0 < HALF - 3 || busy_cycles - b0 > HALF + 3) begin n_fail++; $display("FAIL glitch_busy: got %0d expected %0d +/-3", busy_cycles - b0, HALF); end
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got %b expected 0", rx_busy); end
        n_checks++; if (valid_cycles != v0 || ferr_cnt != f0 || ovr_cnt != o0) begin n_fail++; $display("FAIL glitch_outputs: valid %0d ferr %0d ovr %0d expected 0 0 0", valid_cycles - v0, ferr_cnt - f0, ovr_cnt - o0); end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] d;
        int f0, o0;
        d = 8'h96;
        rx_ready = 1'b1;
        @(posedge clk_50mhz);
        #2;
        line_hold(1'b0, DIV);
        for (int i = 0; i < 4; i++) line_hold(d[i], DIV);
        line_hold(d[4], HALF);
        n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", rx_busy); end
        arst_n = 1'b0;
        #1;
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", rx_busy); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got 0x%02h expected 0x00", rx_data); end
        n_checks++; if (rx_valid !== 1'b0 || rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: valid %b ferr %b ovr %b expected 000", rx_valid, rx_frame_err, rx_overrun); end
        uart_rxd = 1'b1;
        repeat (5) @(posedge clk_50mhz);
        #2;
        arst_n = 1'b1;
        line_hold(1'b1, DIV);
        f0 = ferr_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, DIV, 1'b1);
        line_hold(1'b1, 2 * DIV);
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_missing: %0d bytes outstanding, expected 0", exp_q.size()); end
        n_checks++; if (ferr_cnt != f0 || ovr_cnt != o0) begin n_fail++; $display("FAIL midrst_errors: ferr %0d ovr %0d expected 0 0", ferr_cnt - f0, ovr_cnt - o0); end
    endtask

    task automatic test_baud_tolerance();
        int bits[2];
        logic [7:0] bytes[2];
        int f0, o0;
        bits[0] = BIT_FST; bits[1] = BIT_SLW;
        bytes[0] = 8'h00;  bytes[1] = 8'hFF;
        rx_ready = 1'b1;
        f0 = ferr_cnt; o0 = ovr_cnt;
        for (int r = 0; r < 2; r++) begin
            for (int b = 0; b < 2; b++) begin
                exp_q.push_back(bytes[b]);
                send_frame(bytes[b], bits[r], 1'b1);
                line_hold(1'b1, DIV);
            end
        end
        line_hold(1'b1, DIV);
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL tol_missing: %0d bytes outstanding, expected 0", exp_q.size()); end
        n_checks++; if (ferr_cnt != f0 || ovr_cnt != o0) begin n_fail++; $display("FAIL tol_errors: ferr %0d ovr %0d expected 0 0", ferr_cnt - f0, ovr_cnt - o0); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        valid_cycles = 0;
        ferr_cnt = 0;
        ovr_cnt  = 0;
        busy_cycles = 0;
        valid_prev = 1'b0;
        first_valid_cyc = -1;
        start_cyc = 0;
        test_reset();
        test_single_byte();
        test_back_to_back_overrun();
        test_frame_error();
        test_glitch();
        test_reset_mid_byte();
        test_baud_tolerance();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
